// File: rtl/ah_decode_pkg.sv
// Shared types and constants for the AH address decode dispatcher.
// Bound reset constants are wide so any AW can slice them.
package ah_decode_pkg;

    localparam int AW_DEFAULT          = 25;
    localparam int NUM_CLIENTS_DEFAULT = 4;
    localparam int CW_DEFAULT          = 2;
    localparam int ERRW_DEFAULT        = 16;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        DISPATCH,
        ERR
    } state_t;

    localparam logic CFG_SEL_BOM = 1'b0;
    localparam logic CFG_SEL_TOM = 1'b1;

    // bom above tom disables a window, so these reset values block every hit
    localparam logic [63:0] BOM_RST = '1;
    localparam logic [63:0] TOM_RST = '0;

endpackage

// File: rtl/ah_range_match.sv
// Inclusive unsigned window compare: hit when bom <= field <= tom.
// A window with bom > tom can never hit.
module ah_range_match
    import ah_decode_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) (
    input  logic [AW-1:0] field,
    input  logic [AW-1:0] bom,
    input  logic [AW-1:0] tom,
    output logic          hit
);

    assign hit = (field >= bom) && (field <= tom);

endmodule

// File: rtl/ah_decode_dispatcher.sv
// Range-decodes one ingress field at a time against per-client windows and
// forwards hits to a single client; misses pulse dec_err and are counted.
module ah_decode_dispatcher
    import ah_decode_pkg::*;
#(
    parameter int AW          = AW_DEFAULT,
    parameter int NUM_CLIENTS = NUM_CLIENTS_DEFAULT,
    parameter int CW          = CW_DEFAULT,
    parameter int ERRW        = ERRW_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_wr,
    input  logic [CW-1:0]          cfg_idx,
    input  logic                   cfg_sel,
    input  logic [AW-1:0]          cfg_wdata,
    input  logic                   ingress_valid,
    output logic                   ingress_ready,
    input  logic [AW-1:0]          ingress_pkt_field,
    output logic [NUM_CLIENTS-1:0] egress_valid,
    input  logic [NUM_CLIENTS-1:0] egress_ready,
    output logic [AW-1:0]          egress_pkt_field,
    output logic [CW-1:0]          egress_client,
    output logic                   dec_err,
    output logic [ERRW-1:0]        err_count
);

    state_t                 state_q;
    state_t                 state_d;
    logic [AW-1:0]          bom_q [NUM_CLIENTS];
    logic [AW-1:0]          tom_q [NUM_CLIENTS];
    logic [AW-1:0]          field_q;
    logic [NUM_CLIENTS-1:0] win_hit;
    logic [NUM_CLIENTS-1:0] hit_onehot;
    logic [NUM_CLIENTS-1:0] hit_q;
    logic [CW-1:0]          hit_idx;
    logic [CW-1:0]          sel_q;
    logic [ERRW-1:0]        err_cnt_q;

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_match
        ah_range_match #(
            .AW(AW)
        ) u_match (
            .field(field_q),
            .bom  (bom_q[i]),
            .tom  (tom_q[i]),
            .hit  (win_hit[i])
        );
    end

    // Scan from the top down so the lowest-numbered overlapping window wins
    always_comb begin
        hit_onehot = '0;
        hit_idx    = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (win_hit[i]) begin
                hit_onehot    = '0;
                hit_onehot[i] = 1'b1;
                hit_idx       = CW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ingress_ready = 1'b0;
        case (state_q)
            IDLE: begin
                ingress_ready = 1'b1;
                if (ingress_valid) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = (|win_hit) ? DISPATCH : ERR;
            end
            DISPATCH: begin
                if (|(egress_ready & hit_q)) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field_q   <= '0;
            hit_q     <= '0;
            sel_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            if (state_q == IDLE && ingress_valid) begin
                field_q <= ingress_pkt_field;
            end
            if (state_q == DECODE) begin
                hit_q <= hit_onehot;
                sel_q <= hit_idx;
            end
            if (state_q == ERR && err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    // Indices beyond NUM_CLIENTS match no register and are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                bom_q[i] <= BOM_RST[AW-1:0];
                tom_q[i] <= TOM_RST[AW-1:0];
            end
        end else if (cfg_wr) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (cfg_idx == CW'(i)) begin
                    if (cfg_sel == CFG_SEL_TOM) begin
                        tom_q[i] <= cfg_wdata;
                    end else begin
                        bom_q[i] <= cfg_wdata;
                    end
                end
            end
        end
    end

    assign egress_valid     = (state_q == DISPATCH) ? hit_q : '0;
    assign egress_pkt_field = field_q;
    assign egress_client    = sel_q;
    assign dec_err          = (state_q == ERR);
    assign err_count        = err_cnt_q;

    egress_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (|egress_valid && !(|(egress_valid & egress_ready))) |=>
        (egress_valid == $past(egress_valid) && egress_pkt_field == $past(egress_pkt_field)));

endmodule

// File: tb/tb_ah_decode_dispatcher.sv
// Scoreboard bench for ah_decode_dispatcher: a window model predicts each
// packet's outcome at handshake, a monitor checks whatever the DUT emits.
module tb_ah_decode_dispatcher;
    import ah_decode_pkg::*;

    localparam int AW   = 25;
    localparam int NC   = 4;
    localparam int CW   = 2;
    // Narrow counter so saturation is reachable in a short run
    localparam int ERRW = 8;
    localparam int ERR_MAX = (1 << ERRW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_wr = 1'b0;
    logic [CW-1:0] cfg_idx = '0;
    logic          cfg_sel = 1'b0;
    logic [AW-1:0] cfg_wdata = '0;
    logic          ingress_valid = 1'b0;
    logic          ingress_ready;
    logic [AW-1:0] ingress_pkt_field = '0;
    logic [NC-1:0] egress_valid;
    logic [NC-1:0] egress_ready = '1;
    logic [AW-1:0] egress_pkt_field;
    logic [CW-1:0] egress_client;
    logic          dec_err;
    logic [ERRW-1:0] err_count;

    typedef struct {
        bit            is_err;
        int            client;
        logic [AW-1:0] field;
        int            hs;
    } exp_t;

    exp_t          sb[$];
    logic [AW-1:0] m_bom [NC];
    logic [AW-1:0] m_tom [NC];
    int            m_err_count = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            rdy_mode = 0;
    logic [NC-1:0] manual_ready = '0;

    ah_decode_dispatcher #(
        .AW(AW), .NUM_CLIENTS(NC), .CW(CW), .ERRW(ERRW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_wr           (cfg_wr),
        .cfg_idx          (cfg_idx),
        .cfg_sel          (cfg_sel),
        .cfg_wdata        (cfg_wdata),
        .ingress_valid    (ingress_valid),
        .ingress_ready    (ingress_ready),
        .ingress_pkt_field(ingress_pkt_field),
        .egress_valid     (egress_valid),
        .egress_ready     (egress_ready),
        .egress_pkt_field (egress_pkt_field),
        .egress_client    (egress_client),
        .dec_err          (dec_err),
        .err_count        (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // First window (lowest index) containing the field decides the outcome
    function automatic exp_t modelDecode(input logic [AW-1:0] f);
        exp_t e;
        e.is_err = 1'b1;
        e.client = 0;
        e.field  = f;
        e.hs     = 0;
        for (int i = 0; i < NC; i++) begin
            if (e.is_err && m_bom[i] <= f && f <= m_tom[i]) begin
                e.is_err = 1'b0;
                e.client = i;
            end
        end
        return e;
    endfunction

    task automatic modelResetWindows();
        for (int i = 0; i < NC; i++) begin
            m_bom[i] = '1;
            m_tom[i] = '0;
        end
    endtask

    task automatic cfgWrite(input int idx, input logic sel, input logic [AW-1:0] data);
        cfg_wr    = 1'b1;
        cfg_idx   = CW'(idx);
        cfg_sel   = sel;
        cfg_wdata = data;
        @(negedge clk);
        cfg_wr = 1'b0;
        if (sel == CFG_SEL_TOM) m_tom[idx] = data;
        else                    m_bom[idx] = data;
    endtask

    task automatic setWindow(input int idx, input logic [AW-1:0] lo, input logic [AW-1:0] hi);
        cfgWrite(idx, CFG_SEL_BOM, lo);
        cfgWrite(idx, CFG_SEL_TOM, hi);
    endtask

    task automatic applyStimulus(input logic [AW-1:0] f);
        int   budget;
        exp_t e;
        budget = 0;
        @(negedge clk);
        while (!ingress_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!ingress_ready) begin
            checkOutput("ingress_ready_wait", 32'(ingress_ready), 32'd1);
        end else begin
            ingress_valid     = 1'b1;
            ingress_pkt_field = f;
            e    = modelDecode(f);
            e.hs = cyc;
            sb.push_back(e);
            @(negedge clk);
            ingress_valid     = 1'b0;
            ingress_pkt_field = AW'($urandom);
        end
    endtask

    task automatic waitDrain();
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("scoreboard_drain", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [AW-1:0] pickField();
        int k;
        k = $urandom_range(0, NC - 1);
        case ($urandom_range(0, 4))
            0:       return m_bom[k];
            1:       return m_tom[k];
            2:       return m_bom[k] - 1'b1;
            3:       return m_tom[k] + 1'b1;
            default: return AW'($urandom_range(0, 32'h1_0000));
        endcase
    endfunction

    // Single driver for egress_ready: all-ready, random, or bench-chosen
    initial begin
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       egress_ready = '1;
                1:       egress_ready = NC'($urandom);
                default: egress_ready = manual_ready;
            endcase
        end
    end

    // Monitor: sample mid-low-phase, after every driver has settled
    initial begin
        logic          pend;
        logic [NC-1:0] pv;
        logic [AW-1:0] pf;
        logic [CW-1:0] pc;
        logic          prev_err;
        logic          chk_cnt;
        int            rise;
        exp_t          e;
        pend = 0; prev_err = 0; chk_cnt = 0; rise = 0; pv = '0; pf = '0; pc = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                pend = 0; prev_err = 0; chk_cnt = 0;
            end else begin
                if (chk_cnt) begin
                    checkOutput("err_count", 32'(err_count), 32'(m_err_count));
                    chk_cnt = 0;
                end
                if (pend) begin
                    checkOutput("hold_valid", 32'(egress_valid), 32'(pv));
                    checkOutput("hold_field", 32'(egress_pkt_field), 32'(pf));
                    checkOutput("hold_client", 32'(egress_client), 32'(pc));
                end
                if (|egress_valid) begin
                    checkOutput("egress_onehot", 32'($onehot(egress_valid)), 32'd1);
                    checkOutput("ingress_ready_busy", 32'(ingress_ready), 32'd0);
                    if (!pend) rise = cyc;
                    if (|(egress_valid & egress_ready)) begin
                        pend = 0;
                        if (sb.size() == 0) begin
                            checkOutput("unexpected_egress", 32'(sb.size()), 32'd1);
                        end else begin
                            e = sb.pop_front();
                            checkOutput("expect_hit", 32'(e.is_err), 32'd0);
                            checkOutput("egress_client", 32'(egress_client), 32'(e.client));
                            checkOutput("egress_valid", 32'(egress_valid), 32'(1 << e.client));
                            checkOutput("egress_field", 32'(egress_pkt_field), 32'(e.field));
                            checkOutput("hit_latency", 32'(rise), 32'(e.hs + 2));
                        end
                    end else begin
                        pend = 1; pv = egress_valid; pf = egress_pkt_field; pc = egress_client;
                    end
                end else begin
                    pend = 0;
                end
                if (dec_err) begin
                    checkOutput("err_no_egress", 32'(egress_valid), 32'd0);
                    checkOutput("err_single_pulse", 32'(prev_err), 32'd0);
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_err", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("expect_miss", 32'(e.is_err), 32'd1);
                        checkOutput("miss_latency", 32'(cyc), 32'(e.hs + 2));
                        m_err_count = (m_err_count >= ERR_MAX) ? ERR_MAX : m_err_count + 1;
                        chk_cnt = 1;
                    end
                end
                prev_err = dec_err;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        modelResetWindows();
        repeat (2) @(negedge clk);
        checkOutput("rst_ingress_ready", 32'(ingress_ready), 32'd1);
        checkOutput("rst_egress_valid", 32'(egress_valid), 32'd0);
        checkOutput("rst_egress_field", 32'(egress_pkt_field), 32'd0);
        checkOutput("rst_egress_client", 32'(egress_client), 32'd0);
        checkOutput("rst_dec_err", 32'(dec_err), 32'd0);
        checkOutput("rst_err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] basic decode and boundaries");
        setWindow(0, 25'h0000, 25'h0FFF);
        setWindow(1, 25'h1000, 25'h1FFF);
        setWindow(2, 25'h2000, 25'h5FFF);
        setWindow(3, 25'h6000, 25'h6FFF);
        applyStimulus(25'h1800);
        @(negedge clk); #2;
        checkOutput("first_valid", 32'(egress_valid), 32'b0010);
        checkOutput("first_client", 32'(egress_client), 32'd1);
        checkOutput("first_field", 32'(egress_pkt_field), 32'h1800);
        applyStimulus(25'h0FFF);
        applyStimulus(25'h1000);
        applyStimulus(25'h6FFF);
        applyStimulus(25'h7000);
        @(negedge clk); #2;
        checkOutput("miss_pulse", 32'(dec_err), 32'd1);
        checkOutput("miss_no_valid", 32'(egress_valid), 32'd0);
        @(negedge clk); #2;
        checkOutput("miss_pulse_end", 32'(dec_err), 32'd0);
        checkOutput("miss_count", 32'(err_count), 32'd1);

        $display("[TB] overlap");
        setWindow(0, 25'h0000, 25'h3FFF);
        setWindow(1, 25'h2000, 25'h2FFF);
        applyStimulus(25'h2500);
        waitDrain();

        $display("[TB] backpressure");
        setWindow(0, 25'h0000, 25'h0FFF);
        setWindow(1, 25'h1000, 25'h17FF);
        manual_ready = 4'b1011;
        rdy_mode = 2;
        @(negedge clk);
        applyStimulus(25'h3000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #2;
            checkOutput("bp_ingress_ready", 32'(ingress_ready), 32'd0);
            checkOutput("bp_valid", 32'(egress_valid), 32'b0100);
            checkOutput("bp_field", 32'(egress_pkt_field), 32'h3000);
        end
        manual_ready = 4'b1111;
        @(negedge clk);
        @(negedge clk); #2;
        checkOutput("bp_release_ready", 32'(ingress_ready), 32'd1);
        checkOutput("bp_release_valid", 32'(egress_valid), 32'd0);
        rdy_mode = 0;
        waitDrain();

        $display("[TB] config race");
        applyStimulus(25'h1800);
        cfgWrite(1, CFG_SEL_TOM, 25'h1FFF);
        applyStimulus(25'h1800);
        waitDrain();

        $display("[TB] reset during dispatch");
        manual_ready = '0;
        rdy_mode = 2;
        @(negedge clk);
        applyStimulus(25'h1800);
        @(negedge clk); #2;
        checkOutput("pre_rst_valid", 32'(egress_valid), 32'b0010);
        @(posedge clk); #2;
        rst_n = 1'b0;
        sb.delete();
        modelResetWindows();
        m_err_count = 0;
        #1;
        checkOutput("async_rst_valid", 32'(egress_valid), 32'd0);
        checkOutput("async_rst_ready", 32'(ingress_ready), 32'd1);
        checkOutput("async_rst_count", 32'(err_count), 32'd0);
        checkOutput("async_rst_field", 32'(egress_pkt_field), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 0;
        applyStimulus(25'h0000);
        applyStimulus(25'h1800);
        applyStimulus(25'h6FFF);

        $display("[TB] error counter saturation");
        for (int i = 0; i < ERR_MAX + 5; i++) begin
            applyStimulus(AW'($urandom));
        end
        waitDrain();
        repeat (2) @(negedge clk);
        checkOutput("err_saturated", 32'(err_count), 32'(ERR_MAX));

        $display("[TB] randomized traffic");
        for (int i = 0; i < NC; i++) begin
            logic [AW-1:0] lo;
            lo = AW'($urandom_range(0, 32'hC000));
            if ($urandom_range(0, 4) == 0) setWindow(i, lo + 25'h10, lo);
            else setWindow(i, lo, lo + AW'($urandom_range(0, 32'h3000)));
        end
        rdy_mode = 1;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                cfgWrite($urandom_range(0, NC - 1), 1'($urandom), AW'($urandom_range(0, 32'hF000)));
            end
            applyStimulus(pickField());
            if ($urandom_range(0, 5) == 0) begin
                cfgWrite($urandom_range(0, NC - 1), 1'($urandom), AW'($urandom_range(0, 32'hF000)));
            end
        end
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ah_decode_dispatcher.md
Name: ah_decode_dispatcher

Overview:
- Sequential front end for the AH address decoder: accepts one ingress packet field at a time and range-decodes it against programmable per-client windows.
- On a hit, forwards the packet to exactly one egress client over a valid/ready handshake.
- On a miss, flags a decode error and counts it.
- Sits between the ingress packet parser and the NUM_CLIENTS downstream client ports; all windows are software-configured through a simple write port.

Parameters:
- AW, 25, width of ingress_pkt_field and of each window bound.
- NUM_CLIENTS, 4, number of egress clients (2..8).
- CW, 2, client index width, equal to clog2(NUM_CLIENTS).
- ERRW, 16, width of the error counter.

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_wr  in  1  config write strobe, one write per cycle
- cfg_idx  in  CW  client whose window is written
- cfg_sel  in  1  0 = bottom-of-map (bom, lower bound), 1 = top-of-map (tom, upper bound)
- cfg_wdata  in  AW  bound value
- ingress_valid  in  1  packet present
- ingress_ready  out  1  dispatcher can accept
- ingress_pkt_field  in  AW  address field to decode
- egress_valid  out  NUM_CLIENTS  one-hot; at most one bit set
- egress_ready  in  NUM_CLIENTS  per-client ready
- egress_pkt_field  out  AW  captured field, shared by all clients
- egress_client  out  CW  binary index of the selected client
- dec_err  out  1  one-cycle pulse on a decode miss
- err_count  out  ERRW  saturating miss count

Behaviour:
- Reset (async assert, sync deassert by the upstream reset cell):
  - FSM returns to IDLE; ingress_ready=1.
  - egress_valid=0, egress_pkt_field=0, egress_client=0, dec_err=0, err_count=0.
  - All bom=all-ones, all tom=0, so no window can hit.
  - Reset mid-handshake drops the in-flight packet silently.
- Window match for client i: bom[i] <= field <= tom[i], unsigned, inclusive at both ends.
  - bom>tom means the window is disabled.
  - Overlapping windows: the lowest index wins.
- FSM states: IDLE, DECODE, DISPATCH, ERR.
  - IDLE: ingress_ready=1. On ingress_valid, capture ingress_pkt_field into egress_pkt_field and go to DECODE.
  - DECODE: ingress_ready=0. Evaluate all windows against the captured field using the current registers. Register the one-hot hit vector and its binary index. Any hit goes to DISPATCH; no hit goes to ERR.
  - DISPATCH: egress_valid[sel]=1 and egress_client=sel, both held stable along with egress_pkt_field until egress_ready[sel]=1. The transfer completes in that cycle and the FSM goes to IDLE. egress_ready on non-selected clients is ignored.
  - ERR: dec_err=1 for exactly one cycle. err_count increments, saturating at all-ones. Go to IDLE.
- Latency and throughput:
  - Hit: egress_valid rises 2 cycles after the ingress handshake.
  - Minimum 3 cycles per hit and 3 cycles per miss (IDLE, DECODE, DISPATCH/ERR).
  - No back-to-back acceptance.
- Config writes:
  - Accepted in any state; the register updates at the clock edge.
  - A write in the same cycle as DECODE is not seen by that decode; the old value is used.
  - A write does not affect a packet already in DISPATCH.
- A field equal to a bound hits.
- With NUM_CLIENTS not a power of two, a cfg_idx >= NUM_CLIENTS is ignored.
- egress_valid never deasserts without its matching ready (AXI-style stability). Checked by assertion.

Decomposition:
- Package ah_decode_pkg holds:
  - AW, NUM_CLIENTS, CW defaults
  - state enum {IDLE, DECODE, DISPATCH, ERR}
  - CFG_SEL_BOM=0, CFG_SEL_TOM=1
  - reset bound constants BOM_RST = all-ones, TOM_RST = 0
- Sub-module ah_range_match: combinational window compare (field, bom, tom → hit), instantiated NUM_CLIENTS times in a generate loop.
- The priority encoder stays in the top level.

Test Plan:
- Windows c0=0x0000–0x0FFF, c1=0x1000–0x1FFF, c2=0x2000–0x5FFF, c3=0x6000–0x6FFF; send field 0x1800 with egress_ready=all-ones → egress_valid=0b0010, egress_client=1, egress_pkt_field=0x1800 two cycles after the handshake.
- Boundaries: send 0x0FFF, then 0x1000, then 0x6FFF → clients 0, 1, 3 respectively; send 0x7000 → dec_err pulses once, err_count=1, no egress_valid.
- Overlap: c0=0x0000–0x3FFF, c1=0x2000–0x2FFF; send 0x2500 → client 0 only.
- Backpressure: hold egress_ready[2]=0 for 5 cycles with a 0x3000 packet → egress_valid[2] and egress_pkt_field stay stable, ingress_ready=0 throughout; release ready → one transfer, then IDLE with ingress_ready=1.
- Config race: write c1 tom=0x1FFF in the same cycle as DECODE of 0x1800 while the old tom=0x17FF → miss and dec_err (old value used); resend 0x1800 → hit on client 1.
- Reset: assert rst_n=0 during DISPATCH → egress_valid=0 immediately; all windows disabled, so any field → dec_err; force err_count to saturate at 0xFFFF with no wrap.
